// File: rtl/seg16_scan_decoder.sv
// Readback decoder for the scanned 16-segment display bus: waits for each strobed
// digit's pattern to settle, maps it back to ASCII and reports per-digit changes.
module seg16_scan_decoder #(
  parameter int NUM_DIGITS    = 8,
  parameter int STABLE_CYCLES = 4,
  localparam int DW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [15:0]           seg_n,
  input  logic [NUM_DIGITS-1:0] digit_sel,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [7:0]            out_char,
  output logic [DW-1:0]         out_digit,
  output logic                  out_unknown
);

  localparam logic [7:0] STABLE = 8'(STABLE_CYCLES);

  typedef enum logic [1:0] {IDLE, TRACK, EMIT, DONE} state_t;

  state_t                state, state_n;
  logic [NUM_DIGITS-1:0] samp_sel, track_sel, cur_sel;
  logic [15:0]           samp_seg, track_seg, cur_seg;
  logic [7:0]            cnt;
  logic [7:0]            last_char [NUM_DIGITS];
  logic [NUM_DIGITS-1:0] seen;
  logic [DW-1:0]         track_idx;
  logic [8:0]            dec;
  logic                  samp_onehot, stable_now, changed, new_char;
  logic                  decide, load_out, accept;

  // Table is keyed on the lit-segment mask (bit set = segment on), bit 15..0 = a1..m.
  // Duplicate shapes ("O", ":", "\") are left out so they resolve to "0", "I", ">".
  function automatic logic [8:0] decode16(input logic [15:0] segn);
    logic [15:0] lit;
    lit = ~segn;
    case (lit)
      16'h0000: decode16 = {1'b0, 8'h20};
      16'hFF00: decode16 = {1'b0, 8'h30};
      16'h3008: decode16 = {1'b0, 8'h31};
      16'hEEC0: decode16 = {1'b0, 8'h32};
      16'hFC40: decode16 = {1'b0, 8'h33};
      16'h31C0: decode16 = {1'b0, 8'h34};
      16'hDDC0: decode16 = {1'b0, 8'h35};
      16'hDFC0: decode16 = {1'b0, 8'h36};
      16'hF000: decode16 = {1'b0, 8'h37};
      16'hFFC0: decode16 = {1'b0, 8'h38};
      16'hFDC0: decode16 = {1'b0, 8'h39};
      16'h0014: decode16 = {1'b0, 8'h3B};
      16'h0009: decode16 = {1'b0, 8'h3C};
      16'h0CC0: decode16 = {1'b0, 8'h3D};
      16'h0021: decode16 = {1'b0, 8'h3E};
      16'hE042: decode16 = {1'b0, 8'h3F};
      16'hEF50: decode16 = {1'b0, 8'h40};
      16'hF3C0: decode16 = {1'b0, 8'h41};
      16'hFC52: decode16 = {1'b0, 8'h42};
      16'hCF00: decode16 = {1'b0, 8'h43};
      16'hFC12: decode16 = {1'b0, 8'h44};
      16'hCF80: decode16 = {1'b0, 8'h45};
      16'hC380: decode16 = {1'b0, 8'h46};
      16'hDF40: decode16 = {1'b0, 8'h47};
      16'h33C0: decode16 = {1'b0, 8'h48};
      16'h0012: decode16 = {1'b0, 8'h49};
      16'h3E00: decode16 = {1'b0, 8'h4A};
      16'h0389: decode16 = {1'b0, 8'h4B};
      16'h0F00: decode16 = {1'b0, 8'h4C};
      16'h3328: decode16 = {1'b0, 8'h4D};
      16'h3321: decode16 = {1'b0, 8'h4E};
      16'hE3C0: decode16 = {1'b0, 8'h50};
      16'hFF01: decode16 = {1'b0, 8'h51};
      16'hE3C1: decode16 = {1'b0, 8'h52};
      16'hDC60: decode16 = {1'b0, 8'h53};
      16'hC012: decode16 = {1'b0, 8'h54};
      16'h3F00: decode16 = {1'b0, 8'h55};
      16'h030C: decode16 = {1'b0, 8'h56};
      16'h3305: decode16 = {1'b0, 8'h57};
      16'h002D: decode16 = {1'b0, 8'h58};
      16'h002A: decode16 = {1'b0, 8'h59};
      16'hCC0C: decode16 = {1'b0, 8'h5A};
      16'h4412: decode16 = {1'b0, 8'h5B};
      16'h8812: decode16 = {1'b0, 8'h5D};
      16'h0005: decode16 = {1'b0, 8'h5E};
      16'h0C00: decode16 = {1'b0, 8'h5F};
      16'h0020: decode16 = {1'b0, 8'h60};
      default:  decode16 = {1'b1, 8'h00};
    endcase
  endfunction

  // The tracker keeps running in every state, including while an event waits in EMIT.
  always_ff @(posedge clk) begin
    if (reset) begin
      samp_sel  <= '0;
      samp_seg  <= '0;
      track_sel <= '0;
      track_seg <= '0;
      cnt       <= '0;
    end else begin
      samp_sel  <= digit_sel;
      samp_seg  <= seg_n;
      track_sel <= samp_sel;
      track_seg <= samp_seg;
      if ({samp_sel, samp_seg} != {track_sel, track_seg}) cnt <= 8'd1;
      else if (cnt != STABLE) cnt <= cnt + 8'd1;
    end
  end

  always_comb begin
    track_idx = '0;
    for (int i = 0; i < NUM_DIGITS; i++)
      if (track_sel[i]) track_idx = DW'(i);
  end

  assign dec         = decode16(track_seg);
  assign samp_onehot = $onehot(samp_sel);
  assign stable_now  = (cnt == STABLE) && $onehot(track_sel);
  assign changed     = {samp_sel, samp_seg} != {cur_sel, cur_seg};
  assign new_char    = !seen[track_idx] || (last_char[track_idx] != dec[7:0]);
  assign out_valid   = (state == EMIT);

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n  = state;
    decide   = 1'b0;
    load_out = 1'b0;
    accept   = 1'b0;
    case (state)
      IDLE:  if (samp_onehot) state_n = TRACK;
      TRACK: begin
        if (!samp_onehot) state_n = IDLE;
        else if (stable_now) begin
          decide   = 1'b1;
          load_out = new_char;
          state_n  = new_char ? EMIT : DONE;
        end
      end
      EMIT: begin
        if (out_ready) begin
          accept  = 1'b1;
          state_n = DONE;
        end
      end
      DONE: begin
        if (!samp_onehot) state_n = IDLE;
        else if (changed) state_n = TRACK;
      end
      default: state_n = IDLE;
    endcase
  end

  // cur_* remembers the last decoded input so DONE can spot changes made while EMIT stalled.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_char    <= 8'h00;
      out_digit   <= '0;
      out_unknown <= 1'b0;
      cur_sel     <= '0;
      cur_seg     <= '0;
      seen        <= '0;
      for (int i = 0; i < NUM_DIGITS; i++) last_char[i] <= 8'h00;
    end else begin
      if (decide) begin
        cur_sel <= track_sel;
        cur_seg <= track_seg;
      end
      if (load_out) begin
        out_char    <= dec[7:0];
        out_digit   <= track_idx;
        out_unknown <= dec[8];
      end
      if (accept) begin
        last_char[out_digit] <= out_char;
        seen[out_digit]      <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_seg16_scan_decoder.sv
// Directed bench for seg16_scan_decoder: latency, scan dedup, duplicate shapes,
// unknown patterns, back-pressure, glitch rejection and reset during EMIT.
module tb_seg16_scan_decoder;

  typedef struct packed {
    logic [7:0] ch;
    logic [2:0] dig;
    logic       unk;
  } ev_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] seg_n;
  logic [7:0]  digit_sel;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_char;
  logic [2:0]  out_digit;
  logic        out_unknown;

  int  checks = 0;
  int  errors = 0;
  ev_t evq[$];

  seg16_scan_decoder #(.NUM_DIGITS(8), .STABLE_CYCLES(4)) dut (
    .clk         (clk),
    .reset       (reset),
    .seg_n       (seg_n),
    .digit_sel   (digit_sel),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_char    (out_char),
    .out_digit   (out_digit),
    .out_unknown (out_unknown)
  );

  always #5 clk = ~clk;

  // Record every handshake that will complete on the coming rising edge.
  always @(negedge clk)
    if (!reset && out_valid && out_ready)
      evq.push_back({out_char, out_digit, out_unknown});

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [7:0] sel, input logic [15:0] segn);
    digit_sel = sel;
    seg_n     = segn;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic checkEvent(input string tag, input int idx, input ev_t exp);
    ev_t obs;
    obs = (idx < evq.size()) ? evq[idx] : '1;
    checkOutput(tag, 32'(obs), 32'(exp));
  endtask

  initial begin
    logic [15:0] scan_seg [4];
    logic [15:0] dup_seg  [4];
    logic [7:0]  dup_chr  [4];
    scan_seg = '{16'hCFF7, 16'h113F, 16'h03BF, 16'hCE3F};
    dup_seg  = '{16'h00FF, 16'hFFED, 16'hFFDE, 16'hFFFF};
    dup_chr  = '{8'h30, 8'h49, 8'h3E, 8'h20};

    reset     = 1'b1;
    out_ready = 1'b1;
    applyStimulus(8'h00, 16'hFFFF);
    tick(2);
    checkOutput("rst_valid",   32'(out_valid),   32'd0);
    checkOutput("rst_char",    32'(out_char),    32'h00);
    checkOutput("rst_digit",   32'(out_digit),   32'd0);
    checkOutput("rst_unknown", 32'(out_unknown), 32'd0);

    // "A" on digit 0: valid must appear after exactly the sixth edge.
    reset = 1'b0;
    applyStimulus(8'h01, 16'h0C3F);
    for (int k = 0; k < 5; k++) begin
      tick(1);
      checkOutput($sformatf("lat_low_e%0d", k), 32'(out_valid), 32'd0);
    end
    tick(1);
    checkOutput("lat_high",    32'(out_valid),   32'd1);
    checkOutput("lat_char",    32'(out_char),    32'h41);
    checkOutput("lat_digit",   32'(out_digit),   32'd0);
    checkOutput("lat_unknown", 32'(out_unknown), 32'd0);
    tick(1);
    checkOutput("lat_one_cycle", 32'(out_valid), 32'd0);
    tick(4);
    checkOutput("lat_count", evq.size(), 1);
    checkEvent("lat_event", 0, '{8'h41, 3'd0, 1'b0});
    evq.delete();

    // Two scans of "1234"; only the first scan produces events.
    for (int s = 0; s < 2; s++)
      for (int d = 0; d < 4; d++) begin
        applyStimulus(8'(1 << d), scan_seg[d]);
        tick(8);
      end
    checkOutput("scan_count", evq.size(), 4);
    for (int d = 0; d < 4; d++)
      checkEvent($sformatf("scan_ev%0d", d), d, '{8'h31 + 8'(d), 3'(d), 1'b0});
    evq.delete();

    for (int d = 0; d < 4; d++) begin
      applyStimulus(8'(1 << (d + 4)), dup_seg[d]);
      tick(8);
    end
    checkOutput("dup_count", evq.size(), 4);
    for (int d = 0; d < 4; d++)
      checkEvent($sformatf("dup_ev%0d", d), d, '{dup_chr[d], 3'(d + 4), 1'b0});
    evq.delete();

    applyStimulus(8'h04, 16'h1234);
    tick(8);
    applyStimulus(8'h08, 16'hCE3F);
    tick(8);
    applyStimulus(8'h04, 16'h1234);
    tick(8);
    checkOutput("unk_count", evq.size(), 1);
    checkEvent("unk_event", 0, '{8'h00, 3'd2, 1'b1});
    checkOutput("unk_flag", 32'(out_unknown), 32'd1);
    evq.delete();

    // Stall EMIT while the inputs wander, then settle on "7" at digit 0.
    out_ready = 1'b0;
    applyStimulus(8'h02, 16'h0C3F);
    tick(6);
    checkOutput("bp_valid_start", 32'(out_valid), 32'd1);
    for (int i = 0; i < 20; i++) begin
      if (i < 10) applyStimulus((i % 2 == 0) ? 8'h08 : 8'h40, (i % 2 == 0) ? 16'h023F : 16'h1234);
      else        applyStimulus(8'h01, 16'h0FFF);
      tick(1);
      if (i == 9) checkOutput("bp_char_mid", 32'(out_char), 32'h41);
    end
    checkOutput("bp_valid_end", 32'(out_valid), 32'd1);
    checkOutput("bp_char_end",  32'(out_char),  32'h41);
    checkOutput("bp_digit_end", 32'(out_digit), 32'd1);
    checkOutput("bp_no_xfer",   evq.size(),     0);
    out_ready = 1'b1;
    tick(10);
    checkOutput("bp_count", evq.size(), 2);
    checkEvent("bp_ev0", 0, '{8'h41, 3'd1, 1'b0});
    checkEvent("bp_ev1", 1, '{8'h37, 3'd0, 1'b0});
    evq.delete();

    // Toggle "9"/"8" on digit 5 every 3 cycles: never stable long enough.
    out_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      applyStimulus(8'h20, (i % 2 == 0) ? 16'h023F : 16'h003F);
      tick(3);
    end
    checkOutput("glitch_valid", 32'(out_valid), 32'd0);
    checkOutput("glitch_count", evq.size(),     0);
    tick(8);
    checkOutput("pre_rst_valid", 32'(out_valid), 32'd1);
    checkOutput("pre_rst_char",  32'(out_char),  32'h38);
    checkOutput("pre_rst_digit", 32'(out_digit), 32'd5);

    reset = 1'b1;
    tick(1);
    checkOutput("mid_rst_valid", 32'(out_valid), 32'd0);
    checkOutput("mid_rst_char",  32'(out_char),  32'h00);
    checkOutput("mid_rst_digit", 32'(out_digit), 32'd0);
    reset     = 1'b0;
    out_ready = 1'b1;
    tick(10);
    // Digit 0 showed "7" before reset; it must re-emit because seen was cleared.
    applyStimulus(8'h01, 16'h0FFF);
    tick(8);
    checkOutput("post_rst_count", evq.size(), 2);
    checkEvent("post_rst_ev0", 0, '{8'h38, 3'd5, 1'b0});
    checkEvent("post_rst_ev1", 1, '{8'h37, 3'd0, 1'b0});

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
